parity_stream_calc: RTL and testbench
=====================================

Name: parity_stream_calc

Overview:
- Sequential, parametrised successor to the combinational 32-bit parity calculator.
- Accumulates parity over a multi-word frame arriving on a valid/ready stream delimited by in_last.
- Supports even/odd mode and an optional check against a received parity bit.
- Presents a registered per-frame result on a valid/ready output port; sits between a data source and a link/CRC-lite error monitor.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- CNT_W, 8, width of the frame beat counter; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WIDTH  data word
- in_last  in  1  beat is the final word of the frame
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the last beat
- chk_en  in  1  enable check against chk_bit; sampled on the last beat
- chk_bit  in  1  received parity bit; sampled on the last beat
- word_parity  out  1  registered XOR-reduction of the most recently accepted in_data (raw, mode-independent)
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_parity  out  1  frame parity = XOR of all bits of all frame words, XOR odd_mode
- out_err  out  1  chk_en & (chk_bit != out_parity); 0 when chk_en = 0
- out_count  out  CNT_W  number of beats in frame (saturating)
- out_ovf  out  1  frame beat count exceeded 2^CNT_W-1

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a clk edge clears the state.
  - Reset values: state = IDLE, accumulator = 0, counter = 0, ovf flag = 0, word_parity = 0, out_valid = 0, out_parity = 0, out_err = 0, out_count = 0, out_ovf = 0.
  - rst overrides every other input in the same cycle.
- Beat acceptance occurs when in_valid & in_ready at a clk edge.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. Combinational from state only; no dependency on in_valid.
- States:
  - IDLE: no beat of the current frame accepted yet.
    - Accepted beat with in_last = 0 -> ACCUM, acc = ^in_data, cnt = 1.
    - Accepted beat with in_last = 1 -> HOLD (single-word frame).
  - ACCUM: acc ^= ^in_data and cnt++ on each accepted beat.
    - Accepted beat with in_last = 1 -> HOLD.
    - No beat -> hold state and values.
  - HOLD: out_valid = 1. Outputs stay stable until out_valid & out_ready at a clk edge -> IDLE, acc = 0, cnt = 0, ovf = 0.
- On the last beat, the result registers load:
  - out_parity = acc ^ (^in_data) ^ odd_mode
  - out_err = chk_en & (chk_bit ^ out_parity_next)
  - out_count = cnt+1 (saturated)
  - out_ovf = ovf flag, or this increment saturating
- Latency: out_valid rises on the first clk edge after the last beat is accepted (1 cycle). Result is held indefinitely under backpressure.
- Throughput: one beat per cycle within a frame. A new frame may start the cycle after the result handshake (1 bubble cycle per frame minimum).
- Counter saturation: when cnt == 2^CNT_W-1 and another beat is accepted, cnt holds and ovf sets. Parity continues to accumulate correctly.
- word_parity updates on every accepted beat, including the last; it holds otherwise.
- in_valid with in_ready = 0 (HOLD): the beat is not consumed and has no effect.
- odd_mode, chk_en and chk_bit are don't-care except on the last beat.
- Reset mid-frame or in HOLD: the partial frame and any pending result are discarded; no out_valid is produced for it.

Test Plan:
- WIDTH=32, even, chk_en=0. Frame 32'h5D6, 32'h0, 32'hC (last) -> out_valid 1 cycle after last; out_parity=1, out_count=3, out_err=0, out_ovf=0. word_parity sequence 1,0,0.
- Same frame with odd_mode=1 on the last beat -> out_parity=0. Then chk_en=1, chk_bit=1 -> out_err=1. Then chk_bit=0 -> out_err=0.
- Single-word frame 32'h0 with in_last=1 from IDLE, even -> out_parity=0, out_count=1. Then 32'hFFFFFFFF -> out_parity=0. Then 32'h1 -> out_parity=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 with 32'h1 -> in_ready=0 throughout, outputs unchanged. Next frame parity is unaffected by the held-off beats. Result handshake is exactly one transfer.
- CNT_W=2: 5-beat frame of 32'h1 -> out_count=3, out_ovf=1, out_parity=1 (even). Next frame of 2 beats -> out_count=2, out_ovf=0.
- Assert rst for 1 cycle after 2 beats of a 4-beat frame -> all outputs 0, in_ready=1 next cycle. A following clean frame 32'h3 (last) -> out_parity=0, out_count=1.

Source files
------------

// File: rtl/parity_stream_calc.sv
// Streaming parity calculator: accumulates the XOR of every bit of a
// multi-word frame, applies even/odd mode and an optional check bit on the
// last beat, and holds a registered per-frame result until it is consumed.
module parity_stream_calc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  input  logic             chk_en,
  input  logic             chk_bit,
  output logic             word_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating beat-count increment: sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             word_parity_q, word_parity_d;
  logic             out_parity_q, out_parity_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic beat;
  logic wpar;

  assign in_ready    = (state_q != HOLD);
  assign out_valid   = (state_q == HOLD);
  assign beat        = in_valid & in_ready;
  assign wpar        = ^in_data;
  assign word_parity = word_parity_q;
  assign out_parity  = out_parity_q;
  assign out_err     = out_err_q;
  assign out_count   = out_count_q;
  assign out_ovf     = out_ovf_q;

  // Next-state and accumulator/result update; everything holds by default.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    word_parity_d = word_parity_q;
    out_parity_d  = out_parity_q;
    out_err_d     = out_err_q;
    out_count_d   = out_count_q;
    out_ovf_d     = out_ovf_q;
    case (state_q)
      // IDLE starts with acc/cnt/ovf cleared, so both states share one path.
      IDLE, ACCUM: begin
        if (beat) begin
          word_parity_d = wpar;
          acc_d         = acc_q ^ wpar;
          cnt_d         = sat_inc(cnt_q);
          ovf_d         = ovf_q | (cnt_q == CNT_MAX);
          if (in_last) begin
            state_d      = HOLD;
            out_parity_d = acc_q ^ wpar ^ odd_mode;
            out_err_d    = chk_en & (chk_bit ^ out_parity_d);
            out_count_d  = sat_inc(cnt_q);
            out_ovf_d    = ovf_q | (cnt_q == CNT_MAX);
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= 1'b0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      word_parity_q <= 1'b0;
      out_parity_q  <= 1'b0;
      out_err_q     <= 1'b0;
      out_count_q   <= '0;
      out_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      word_parity_q <= word_parity_d;
      out_parity_q  <= out_parity_d;
      out_err_q     <= out_err_d;
      out_count_q   <= out_count_d;
      out_ovf_q     <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_parity_stream_calc.sv
// Directed bench for parity_stream_calc: a default-width instance and a
// CNT_W=2 instance share all inputs so counter saturation can be observed.
module tb_parity_stream_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        odd_mode;
  logic        chk_en;
  logic        chk_bit;
  logic        out_ready;

  logic       in_ready_a, word_parity_a, out_valid_a, out_parity_a, out_err_a, out_ovf_a;
  logic [7:0] out_count_a;
  logic       in_ready_b, word_parity_b, out_valid_b, out_parity_b, out_err_b, out_ovf_b;
  logic [1:0] out_count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parity_stream_calc #(.WIDTH(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
    .chk_en(chk_en), .chk_bit(chk_bit), .word_parity(word_parity_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_parity(out_parity_a),
    .out_err(out_err_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );

  parity_stream_calc #(.WIDTH(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .odd_mode(odd_mode),
    .chk_en(chk_en), .chk_bit(chk_bit), .word_parity(word_parity_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_parity(out_parity_b),
    .out_err(out_err_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat for one clock, sample 1 time unit after the edge.
  task automatic send_beat(input logic [31:0] d, input logic last,
                           input logic odd, input logic ce, input logic cb);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    odd_mode = odd;
    chk_en   = ce;
    chk_bit  = cb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called 1 unit after the last-beat edge: result must already be valid.
  task automatic check_result(input string tag, input logic par, input logic err,
                              input logic [7:0] cnt, input logic ovf);
    chk({tag, ".valid"}, out_valid_a, 1'b1);
    chk({tag, ".parity"}, out_parity_a, par);
    chk({tag, ".err"}, out_err_a, err);
    chk({tag, ".count"}, out_count_a, cnt);
    chk({tag, ".ovf"}, out_ovf_a, ovf);
  endtask

  // Single-cycle result handshake, then the result must be gone.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, out_valid_a, 1'b0);
    chk({tag, ".ready_back"}, in_ready_a, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".in_ready"}, in_ready_a, 1'b1);
    chk({tag, ".word_par"}, word_parity_a, 1'b0);
    chk({tag, ".valid"}, out_valid_a, 1'b0);
    chk({tag, ".parity"}, out_parity_a, 1'b0);
    chk({tag, ".err"}, out_err_a, 1'b0);
    chk({tag, ".count"}, out_count_a, 8'd0);
    chk({tag, ".ovf"}, out_ovf_a, 1'b0);
    chk({tag, ".b_valid"}, out_valid_b, 1'b0);
    chk({tag, ".b_count"}, out_count_b, 2'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    odd_mode = 1'b0; chk_en = 1'b0; chk_bit = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst0");

    // Three-word even frame: bit counts 7, 0, 2 -> parity 1.
    send_beat(32'h5D6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f1.wp0", word_parity_a, 1'b1);
    chk("f1.busy", out_valid_a, 1'b0);
    send_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f1.wp1", word_parity_a, 1'b0);
    send_beat(32'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("f1.wp2", word_parity_a, 1'b0);
    check_result("f1", 1'b1, 1'b0, 8'd3, 1'b0);
    consume("f1");

    // Same frame, odd mode.
    send_beat(32'h5D6, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    check_result("f2", 1'b0, 1'b0, 8'd3, 1'b0);
    consume("f2");

    // Odd mode with check bit 1 against parity 0 -> error.
    send_beat(32'h5D6, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'hC, 1'b1, 1'b1, 1'b1, 1'b1);
    check_result("f3", 1'b0, 1'b1, 8'd3, 1'b0);
    consume("f3");

    // Check bit 0 matches -> no error.
    send_beat(32'h5D6, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'hC, 1'b1, 1'b1, 1'b1, 1'b0);
    check_result("f4", 1'b0, 1'b0, 8'd3, 1'b0);
    consume("f4");

    // Single-word frames.
    send_beat(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("s0", 1'b0, 1'b0, 8'd1, 1'b0);
    consume("s0");
    send_beat(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s1.wp", word_parity_a, 1'b0);
    check_result("s1", 1'b0, 1'b0, 8'd1, 1'b0);
    consume("s1");
    send_beat(32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("s2.wp", word_parity_a, 1'b1);
    check_result("s2", 1'b1, 1'b0, 8'd1, 1'b0);

    // Backpressure: keep offering 32'h1 while the result is held.
    in_valid = 1'b1;
    in_data  = 32'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.in_ready", in_ready_a, 1'b0);
      chk("bp.valid", out_valid_a, 1'b1);
      chk("bp.parity", out_parity_a, 1'b1);
      chk("bp.count", out_count_a, 8'd1);
      chk("bp.wp", word_parity_a, 1'b1);
    end
    in_valid = 1'b0;
    consume("bp");
    // One idle cycle: nothing must reappear after the single transfer.
    @(posedge clk);
    #1;
    chk("bp.one_xfer", out_valid_a, 1'b0);
    send_beat(32'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("bp_next", 1'b0, 1'b0, 8'd1, 1'b0);
    consume("bp_next");

    // Five beats of 32'h1: wide counter 5, narrow counter saturates at 3.
    for (int i = 0; i < 4; i++) send_beat(32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("sat_a", 1'b1, 1'b0, 8'd5, 1'b0);
    chk("sat_b.valid", out_valid_b, 1'b1);
    chk("sat_b.count", out_count_b, 2'd3);
    chk("sat_b.ovf", out_ovf_b, 1'b1);
    chk("sat_b.parity", out_parity_b, 1'b1);
    consume("sat");

    // Overflow flag must not leak into the next frame.
    send_beat(32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat2_b.count", out_count_b, 2'd2);
    chk("sat2_b.ovf", out_ovf_b, 1'b0);
    chk("sat2_b.parity", out_parity_b, 1'b0);
    consume("sat2");

    // Reset after two beats of a four-beat frame discards the frame.
    send_beat(32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(32'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst1");
    send_beat(32'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    check_result("post_rst", 1'b0, 1'b0, 8'd1, 1'b0);
    consume("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
